// File: rtl/mem_unit.sv
// Memory subsystem behind the load/store control FSM: MAR, MDR and a word-addressed RAM.
// Requests complete after WAIT_CYCLES extra busy cycles and are acknowledged through MFC.
module mem_unit #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  input  logic              MAR_EN,
  input  logic              mem_EN,
  input  logic              mem_RW,
  input  logic              MDR_EN_read,
  input  logic              MDR_EN_write,
  input  logic              MDR_out,
  output logic              MFC
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              op_rw;
  logic [CNT_W-1:0]  count;
  logic              mfc_q;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] ram [DEPTH];

  logic complete;
  logic ram_we;
  logic read_load_now;
  logic read_load_late;

  assign complete       = (state == BUSY) && mem_EN && (count == WAIT_LAST);
  assign ram_we         = complete && !op_rw;
  assign read_load_now  = complete && op_rw && MDR_EN_read;
  assign read_load_late = (state == DONE) && op_rw && MDR_EN_read;

  assign bus_out = MDR_out ? mdr : '0;
  assign MFC     = mfc_q;

  // RAM contents survive reset; only a completed write changes them.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[op_addr] <= op_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (complete && op_rw) begin
      read_data <= ram[op_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mar      <= '0;
      mdr      <= '0;
      op_addr  <= '0;
      op_wdata <= '0;
      op_rw    <= 1'b0;
      count    <= '0;
      mfc_q    <= 1'b0;
    end else begin
      if (MAR_EN) begin
        mar <= bus_in[ADDR_W-1:0];
      end

      // A bus load into MDR beats read data; the read value stays held for DONE.
      if (MDR_EN_write) begin
        mdr <= bus_in;
      end else if (read_load_now) begin
        mdr <= ram[op_addr];
      end else if (read_load_late) begin
        mdr <= read_data;
      end

      case (state)
        IDLE: begin
          mfc_q <= 1'b0;
          if (mem_EN) begin
            op_addr  <= MAR_EN ? bus_in[ADDR_W-1:0] : mar;
            op_wdata <= MDR_EN_write ? bus_in : mdr;
            op_rw    <= mem_RW;
            count    <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          mfc_q <= 1'b0;
          if (!mem_EN) begin
            state <= IDLE;
          end else if (count == WAIT_LAST) begin
            state <= DONE;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        DONE: begin
          if (mem_EN) begin
            mfc_q <= 1'b1;
          end else begin
            mfc_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          mfc_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_unit.sv
// Bench for mem_unit: directed scenarios plus random write/read traffic against a
// word-array reference model; a second instance exercises the zero-wait configuration.
module tb_mem_unit;

  localparam int W0 = 2;
  localparam int W1 = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_in, bus_out;
  logic        MAR_EN, mem_EN, mem_RW, MDR_EN_read, MDR_EN_write, MDR_out, MFC;
  logic [15:0] z_bus_in, z_bus_out;
  logic        z_MAR_EN, z_mem_EN, z_mem_RW, z_MDR_EN_read, z_MDR_EN_write, z_MDR_out, z_MFC;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_ram [256];
  logic [7:0]  model_mar;
  logic [15:0] model_mdr;
  logic [7:0]  written_q[$];

  always #5 clk = ~clk;

  mem_unit #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(W0)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .bus_out(bus_out),
    .MAR_EN(MAR_EN), .mem_EN(mem_EN), .mem_RW(mem_RW),
    .MDR_EN_read(MDR_EN_read), .MDR_EN_write(MDR_EN_write),
    .MDR_out(MDR_out), .MFC(MFC)
  );

  mem_unit #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(W1)) dut_zero (
    .clk(clk), .rst(rst), .bus_in(z_bus_in), .bus_out(z_bus_out),
    .MAR_EN(z_MAR_EN), .mem_EN(z_mem_EN), .mem_RW(z_mem_RW),
    .MDR_EN_read(z_MDR_EN_read), .MDR_EN_write(z_MDR_EN_write),
    .MDR_out(z_MDR_out), .MFC(z_MFC)
  );

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mdr(input string tag);
    MDR_out = 1'b1;
    #1;
    check_output({tag, "_mdr"}, bus_out, model_mdr);
    MDR_out = 1'b0;
    #1;
    check_output({tag, "_bus0"}, bus_out, 16'h0000);
  endtask

  task automatic load_mar(input logic [15:0] v);
    bus_in = v;
    MAR_EN = 1'b1;
    tick();
    MAR_EN = 1'b0;
    model_mar = v[7:0];
  endtask

  task automatic load_mdr(input logic [15:0] v);
    bus_in = v;
    MDR_EN_write = 1'b1;
    tick();
    MDR_EN_write = 1'b0;
    model_mdr = v;
  endtask

  // Issues one request using whatever MAR_EN/MDR_EN_write/bus_in the caller left set up.
  task automatic run_op(input string tag, input logic rw, input logic rd_en, input logic late);
    logic [7:0]  a;
    logic [15:0] wd;
    int          edges;
    a  = MAR_EN ? bus_in[7:0] : model_mar;
    wd = MDR_EN_write ? bus_in : model_mdr;
    if (MAR_EN) model_mar = bus_in[7:0];
    if (MDR_EN_write) model_mdr = bus_in;
    mem_RW = rw;
    MDR_EN_read = rd_en;
    mem_EN = 1'b1;
    tick();
    MAR_EN = 1'b0;
    MDR_EN_write = 1'b0;
    mem_RW = ~rw;
    edges = 1;
    while (MFC !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    check_output({tag, "_lat"}, 16'(edges), 16'(W0 + 3));
    if (!rw) begin
      model_ram[a] = wd;
      written_q.push_back(a);
    end else if (rd_en) begin
      model_mdr = model_ram[a];
    end
    if (late) begin
      MDR_out = 1'b1;
      #1;
      check_output({tag, "_pre"}, bus_out, model_mdr);
      MDR_out = 1'b0;
      MDR_EN_read = 1'b1;
      tick();
      MDR_EN_read = 1'b0;
      check_output({tag, "_hold"}, 16'(MFC), 16'h0001);
      if (rw) model_mdr = model_ram[a];
    end
    mem_EN = 1'b0;
    MDR_EN_read = 1'b0;
    check_output({tag, "_mfc"}, 16'(MFC), 16'h0001);
    tick();
    check_output({tag, "_drop"}, 16'(MFC), 16'h0000);
  endtask

  task automatic z_run(input string tag, input logic rw);
    int edges;
    z_mem_RW = rw;
    z_MDR_EN_read = rw;
    z_mem_EN = 1'b1;
    tick();
    z_MAR_EN = 1'b0;
    z_MDR_EN_write = 1'b0;
    edges = 1;
    while (z_MFC !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    check_output({tag, "_lat"}, 16'(edges), 16'(W1 + 3));
    z_mem_EN = 1'b0;
    z_MDR_EN_read = 1'b0;
    tick();
    check_output({tag, "_drop"}, 16'(z_MFC), 16'h0000);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0]  ra;
    logic [15:0] rd;
    rst = 1'b0;
    {bus_in, MAR_EN, mem_EN, mem_RW, MDR_EN_read, MDR_EN_write, MDR_out} = '0;
    {z_bus_in, z_MAR_EN, z_mem_EN, z_mem_RW, z_MDR_EN_read, z_MDR_EN_write, z_MDR_out} = '0;
    model_mar = 8'h00;
    model_mdr = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_mfc", 16'(MFC), 16'h0000);
    check_mdr("reset");
    rst = 1'b1;
    tick();

    // Seed known contents, including the write/read pair at addr 5.
    load_mar(16'h0000); load_mdr(16'h2222); run_op("wr0", 1'b0, 1'b0, 1'b0);
    load_mar(16'h0005); load_mdr(16'hA55A); run_op("wr5", 1'b0, 1'b0, 1'b0);
    load_mar(16'h0012); load_mdr(16'h0BB0); run_op("wr12", 1'b0, 1'b0, 1'b0);
    load_mar(16'h0003); load_mdr(16'h3333); run_op("wr3", 1'b0, 1'b0, 1'b0);
    load_mar(16'h0007); load_mdr(16'h00C3); run_op("wr7", 1'b0, 1'b0, 1'b0);

    load_mar(16'h0005); load_mdr(16'h0000);
    run_op("rd5", 1'b1, 1'b1, 1'b0);
    check_mdr("rd5");

    // Same-cycle MAR load must steer the read to 0x12, not the stale MAR of 5.
    bus_in = 16'h0012;
    MAR_EN = 1'b1;
    run_op("bypass", 1'b1, 1'b1, 1'b0);
    check_mdr("bypass");

    // Aborted write leaves RAM[3] alone and returns straight to IDLE.
    load_mar(16'h0003); load_mdr(16'h1234);
    mem_RW = 1'b0;
    mem_EN = 1'b1;
    tick();
    check_output("abort_busy0", 16'(MFC), 16'h0000);
    tick();
    mem_EN = 1'b0;
    tick();
    check_output("abort_mfc", 16'(MFC), 16'h0000);
    run_op("abort_rd3", 1'b1, 1'b1, 1'b0);
    check_mdr("abort_rd3");

    load_mdr(16'h5A5A); load_mar(16'h0007);
    run_op("late", 1'b1, 1'b0, 1'b1);
    check_mdr("late");

    // Reset in the middle of a write: state, MAR and MDR clear, RAM untouched.
    load_mar(16'h0005); load_mdr(16'hBEEF);
    mem_RW = 1'b0;
    mem_EN = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    model_mar = 8'h00;
    model_mdr = 16'h0000;
    check_output("rst_mfc", 16'(MFC), 16'h0000);
    check_mdr("rst");
    mem_EN = 1'b0;
    rst = 1'b1;
    tick();
    run_op("rst_rd0", 1'b1, 1'b1, 1'b0);
    check_mdr("rst_rd0");
    load_mar(16'h0005);
    run_op("rst_rd5", 1'b1, 1'b1, 1'b0);
    check_mdr("rst_rd5");

    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        ra = 8'($urandom);
        rd = 16'($urandom);
        load_mar({8'($urandom), ra});
        load_mdr(rd);
        run_op("rnd_wr", 1'b0, 1'b0, 1'b0);
      end else begin
        ra = written_q[$urandom_range(0, written_q.size() - 1)];
        load_mar({8'($urandom), ra});
        run_op("rnd_rd", 1'b1, 1'b1, 1'b0);
        check_mdr("rnd_rd");
      end
    end

    // Zero-wait instance: upper bus bits are dropped on the MAR load.
    z_bus_in = 16'h0105;
    z_MAR_EN = 1'b1;
    tick();
    z_MAR_EN = 1'b0;
    z_bus_in = 16'h7E7E;
    z_MDR_EN_write = 1'b1;
    tick();
    z_MDR_EN_write = 1'b0;
    z_run("z_wr", 1'b0);
    z_bus_in = 16'h0000;
    z_MDR_EN_write = 1'b1;
    tick();
    z_MDR_EN_write = 1'b0;
    z_run("z_rd", 1'b1);
    z_MDR_out = 1'b1;
    #1;
    check_output("z_rd_data", z_bus_out, 16'h7E7E);
    z_MDR_out = 1'b0;
    z_bus_in = 16'h0000;
    z_MDR_EN_write = 1'b1;
    tick();
    z_MDR_EN_write = 1'b0;
    z_bus_in = 16'hFF05;
    z_MAR_EN = 1'b1;
    z_run("z_wrap", 1'b1);
    z_MDR_out = 1'b1;
    #1;
    check_output("z_wrap_data", z_bus_out, 16'h7E7E);
    z_MDR_out = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_unit.md
Name: mem_unit

Overview:
- Memory subsystem that sits directly downstream of the load/store control FSM.
- Holds the MAR, the MDR and a synchronous word-addressed RAM.
- Executes read and write requests issued through MAR_EN / mem_EN / mem_RW / MDR_* strobes after a programmable wait-state delay.
- Returns the MFC (memory function complete) handshake that advances the FSM.

Parameters:
- ADDR_W, 8, address width; RAM depth = 2**ADDR_W words.
- DATA_W, 16, word and bus width.
- WAIT_CYCLES, 2, extra cycles spent in BUSY before completion (0 allowed).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- bus_in  input  DATA_W  internal data bus (source for MAR and MDR loads).
- bus_out  output  DATA_W  MDR value when MDR_out=1, else 0.
- MAR_EN  input  1  load MAR <= bus_in[ADDR_W-1:0].
- mem_EN  input  1  memory request; held high until MFC is seen.
- mem_RW  input  1  1 = read, 0 = write; sampled at request start.
- MDR_EN_read  input  1  allow MDR to capture RAM read data on read completion.
- MDR_EN_write  input  1  load MDR <= bus_in (write data staging).
- MDR_out  input  1  drive MDR onto bus_out.
- MFC  output  1  memory function complete.

Behaviour:
- Reset (rst=0, async): state=IDLE, MAR=0, MDR=0, MFC=0, wait counter=0. RAM contents are not reset. A reset mid-operation aborts it: no RAM write, no MFC.
- MAR_EN and MDR_EN_write load on the rising edge in any state. A request already in progress uses its latched copies, so mid-operation loads do not affect it.
- bus_out is combinational: MDR_out ? MDR : 0.
- FSM IDLE:
  - Stay while mem_EN=0.
  - On mem_EN=1, latch op_addr, op_rw=mem_RW and op_wdata, clear counter, go to BUSY.
  - op_addr = MAR_EN ? bus_in[ADDR_W-1:0] : MAR, i.e. a same-cycle MAR load is bypassed.
  - op_wdata = MDR_EN_write ? bus_in : MDR, same bypass rule.
- FSM BUSY:
  - mem_EN=0: abort, go to IDLE, no side effects.
  - Else if counter==WAIT_CYCLES: complete and go to DONE. Otherwise counter+1.
  - Completion, write (op_rw=0): RAM[op_addr] <= op_wdata.
  - Completion, read (op_rw=1): if MDR_EN_read=1 in that cycle, MDR <= RAM[op_addr]. The read value is also held internally so a late MDR_EN_read still loads it (see DONE).
- FSM DONE:
  - MFC=1 (registered, asserted from the first DONE cycle).
  - For a read, MDR_EN_read=1 in DONE loads MDR <= held read data.
  - Stay while mem_EN=1. On mem_EN=0: MFC drops next edge, go to IDLE.
  - A new request is accepted only from IDLE, so there is at least one idle cycle between operations.
- Latency: mem_EN rising edge sampled at edge N gives MFC high after edge N+WAIT_CYCLES+2.
- Priority within one edge: MDR_EN_write has priority over a read-completion load of MDR. The bus load wins; the read data is still held for DONE.
- mem_RW or MAR changes during BUSY/DONE are ignored for the current op.
- Address wraps naturally: bus_in bits above ADDR_W-1 are discarded.

Test Plan:
- Reset: assert rst=0 mid-BUSY of a write of 16'hBEEF to addr 5 -> MFC=0, MAR=0, MDR=0 immediately; later read of addr 5 does not return 16'hBEEF.
- Write then read, WAIT_CYCLES=2:
  - Write: bus_in=16'h0005 with MAR_EN; bus_in=16'hA55A with MDR_EN_write; mem_EN=1, mem_RW=0 -> MFC rises 4 edges after request; drop mem_EN -> MFC=0 next edge.
  - Read back: mem_RW=1, MDR_EN_read=1, then MDR_out=1 -> bus_out=16'hA55A.
- Bypass: same-cycle MAR_EN (bus_in=16'h0012) and mem_EN read -> data comes from addr 0x12, not the previous MAR.
- Abort: drop mem_EN during BUSY of a write of 16'h1234 to addr 3 -> no MFC, RAM[3] unchanged, state IDLE next edge.
- Late MDR load: read of addr 7 (holding 16'h00C3) with MDR_EN_read=0 at completion, then pulsed in DONE -> MDR=16'h00C3; with MDR_out=0 -> bus_out=0.
- WAIT_CYCLES=0 and address wrap: bus_in=16'h0105 with MAR_EN -> MAR=8'h05; read completes with MFC 2 edges after request.
